// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath control line, with programmable memory wait states.
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [3:0]  ALU_ADD  = 4'b0000,
  parameter logic [3:0]  ALU_SUB  = 4'b0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] inst,
  input  logic        zero,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        illegal_op,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_EXR  = 4'd3,
    S_EXI    = 4'd4,  S_WB    = 4'd5,  S_ADDR   = 4'd6,  S_MRD  = 4'd7,
    S_MWB    = 4'd8,  S_MWR   = 4'd9,  S_BR     = 4'd10, S_JMP  = 4'd11,
    S_ILL    = 4'd12, S_HALT  = 4'd13
  } state_e;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       illegal_op;
    logic       halted;
  } ctrl_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [3:0] opcode;
  logic       wait_done;
  logic       br_take;
  logic       unused_inst_bits;

  assign opcode           = inst[15:12];
  assign wait_done        = (cnt_q == WAIT_LAST);
  assign unused_inst_bits = ^inst[11:4];

  // Control word for a state; the fetch strobes fire only on the last wait cycle.
  function automatic ctrl_t decode(input state_e s, input logic [3:0] cnt,
                                   input logic [3:0] funct);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = (cnt == WAIT_LAST);
        c.pc_write  = (cnt == WAIT_LAST);
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_EXR: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = funct;
      end
      S_EXI, S_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_WB:  c.reg_write = 1'b1;
      S_MRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_BR: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = 2'b01;
      end
      S_JMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      S_ILL:   c.illegal_op = 1'b1;
      S_HALT:  c.halted     = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          4'b0000:          state_d = S_EXR;
          4'b0001:          state_d = S_EXI;
          4'b0010, 4'b0011: state_d = S_ADDR;
          4'b0100, 4'b0101: state_d = S_BR;
          4'b0110:          state_d = S_JMP;
          4'b1111:          state_d = S_HALT;
          default:          state_d = S_ILL;
        endcase
      end
      S_EXR, S_EXI: state_d = S_WB;
      S_ADDR:       state_d = opcode[0] ? S_MWR : S_MRD;
      S_MRD:        state_d = wait_done ? S_MWB : S_MRD;
      S_MWR:        state_d = wait_done ? S_FETCH : S_MWR;
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_FETCH;
    endcase

    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == S_FETCH || state_q == S_MRD || state_q == S_MWR)) begin
      cnt_d = cnt_q + 4'd1;
    end

    ctrl_d = decode(state_d, cnt_d, inst[3:0]);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Branch decision is the one Mealy term: beq writes on zero, bne (inst[12]=1) on ~zero.
  assign br_take = (state_q == S_BR) & (zero ^ inst[12]);

  assign ir_write   = ctrl_q.ir_write;
  assign pc_write   = ctrl_q.pc_write | br_take;
  assign pc_src     = ctrl_q.pc_src;
  assign iord       = ctrl_q.iord;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign alu_op     = ctrl_q.alu_op;
  assign illegal_op = ctrl_q.illegal_op;
  assign halted     = ctrl_q.halted;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: two instances (MEM_WAIT 0 and 2)
// compared cycle by cycle against an instruction-level expected control trace.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic [15:0] inst_s [2];
  logic        zero_s [2];
  logic [21:0] obs    [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       ir_write, pc_write, iord, mem_read, mem_write, reg_write;
    logic       mem_to_reg, alu_src_a, illegal_op, halted;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_op, state;

    multicycle_control #(.MEM_WAIT(2 * g)) u_dut (
      .clock      (clk),
      .reset      (rst[g]),
      .inst       (inst_s[g]),
      .zero       (zero_s[g]),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .illegal_op (illegal_op),
      .halted     (halted),
      .state      (state)
    );

    assign obs[g] = {state, ir_write, pc_write, pc_src, iord, mem_read, mem_write,
                     reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                     illegal_op, halted};
  end

  // Packs one cycle's expected state and control lines in the same order as obs.
  function automatic logic [21:0] v(input int st, input bit irw, input bit pcw,
                                    input bit [1:0] pcs, input bit io, input bit mr,
                                    input bit mwr, input bit rw, input bit m2r,
                                    input bit asa, input bit [1:0] asb,
                                    input bit [3:0] op, input bit ill, input bit hlt);
    return {4'(st), irw, pcw, pcs, io, mr, mwr, rw, m2r, asa, asb, op, ill, hlt};
  endfunction

  // Whole-instruction trace: fetch phase, decode, then the opcode's own phases.
  task automatic model(input logic [15:0] ins, input bit z, input int mw);
    exp_q.delete();
    for (int k = 0; k <= mw; k++)
      exp_q.push_back(v(1, k == mw, k == mw, 2'b00, 0, 1, 0, 0, 0, 0, 2'b01, 4'h0, 0, 0));
    exp_q.push_back(v(2, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 4'h0, 0, 0));
    case (ins[15:12])
      4'h0: begin
        exp_q.push_back(v(3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, ins[3:0], 0, 0));
        exp_q.push_back(v(5, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 4'h0, 0, 0));
      end
      4'h1: begin
        exp_q.push_back(v(4, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b10, 4'h0, 0, 0));
        exp_q.push_back(v(5, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 4'h0, 0, 0));
      end
      4'h2: begin
        exp_q.push_back(v(6, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b10, 4'h0, 0, 0));
        for (int k = 0; k <= mw; k++)
          exp_q.push_back(v(7, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0));
        exp_q.push_back(v(8, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 4'h0, 0, 0));
      end
      4'h3: begin
        exp_q.push_back(v(6, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b10, 4'h0, 0, 0));
        for (int k = 0; k <= mw; k++)
          exp_q.push_back(v(9, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 4'h0, 0, 0));
      end
      4'h4, 4'h5: begin
        bit taken;
        taken = (ins[15:12] == 4'h4) ? z : !z;
        exp_q.push_back(v(10, 0, taken, 2'b01, 0, 0, 0, 0, 0, 1, 2'b00, 4'h1, 0, 0));
      end
      4'h6: exp_q.push_back(v(11, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0));
      4'hF: begin
        for (int k = 0; k < 20; k++)
          exp_q.push_back(v(13, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 1));
      end
      default: exp_q.push_back(v(12, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 1, 0));
    endcase
  endtask

  task automatic check(input string tag, input logic [21:0] o, input logic [21:0] e);
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Entered and left at posedge+1 with the DUT in S_FETCH; limit>=0 stops early.
  task automatic run_instr(input int d, input logic [15:0] ins, input bit z,
                           input int limit);
    model(ins, z, 2 * d);
    inst_s[d] = ins;
    zero_s[d] = z;
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      check($sformatf("d%0d_i%h_z%0d_c%0d", d, ins, z, i), obs[d], exp_q[i]);
      if (limit >= 0 && i == limit) return;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    #1;
    check($sformatf("d%0d_rst_async", d), obs[d], '0);
    @(posedge clk);
    #1;
    check($sformatf("d%0d_rst_held", d), obs[d], '0);
    rst[d] = 1'b0;
    #1;
    check($sformatf("d%0d_init", d), obs[d], '0);
    @(posedge clk);
    #1;
  endtask

  task automatic random_run(input int d, input int n);
    logic [15:0] ins;
    int unsigned op;
    for (int i = 0; i < n; i++) begin
      op  = $urandom_range(0, 14);
      ins = {op[3:0], 12'($urandom)};
      run_instr(d, ins, 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    rst[0] = 1'b1;  rst[1] = 1'b1;
    inst_s[0] = '0; inst_s[1] = '0;
    zero_s[0] = 1'b0; zero_s[1] = 1'b0;
    @(posedge clk);
    #1;

    do_reset(0);
    run_instr(0, 16'h0000, 1'b0, -1);
    run_instr(0, 16'h2345, 1'b0, -1);
    run_instr(0, 16'h4000, 1'b1, -1);
    run_instr(0, 16'h4000, 1'b0, -1);
    run_instr(0, 16'h5000, 1'b1, -1);
    run_instr(0, 16'h5000, 1'b0, -1);
    run_instr(0, 16'h8000, 1'b0, -1);
    run_instr(0, 16'h6123, 1'b0, -1);
    run_instr(0, 16'h1fff, 1'b0, -1);
    random_run(0, 40);
    run_instr(0, 16'hF000, 1'b0, -1);
    do_reset(0);
    run_instr(0, 16'h0007, 1'b0, -1);

    do_reset(1);
    run_instr(1, 16'h3000, 1'b0, -1);
    run_instr(1, 16'h2345, 1'b0, -1);
    run_instr(1, 16'h2000, 1'b0, 5);
    #3;
    do_reset(1);
    run_instr(1, 16'h0009, 1'b0, -1);
    random_run(1, 30);
    run_instr(1, 16'hF000, 1'b0, -1);
    do_reset(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM. It is the consumer side of the 16-bit instruction register.
- It reads the latched instruction (`inst`) and sequences fetch, decode, execute, memory and writeback. It drives `ir_write` back to the instruction register, and drives every datapath control line for the processor datapath.
- It issues exactly one instruction at a time. Each memory access can be stretched by a programmable number of wait cycles.

Parameters:
- MEM_WAIT, 0, extra stall cycles inserted in each memory state (0..15).
- ALU_ADD, 4'b0000, `alu_op` code for address/PC arithmetic.
- ALU_SUB, 4'b0001, `alu_op` code for branch compare.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces S_INIT
- inst  in  16  current instruction register contents
- zero  in  1  ALU zero flag, sampled in S_BR
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- iord  out  1  0 memory address = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback source: 1 memory data, 0 ALUOut
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 reg B, 01 const 2, 10 sign-extended imm, 11 imm<<1
- alu_op  out  4  ALU function
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  high while in S_HALT
- state  out  4  current state encoding, for debug

Behaviour:
- Opcode is `inst[15:12]`:
  - 0000 R-type; `alu_op` = `inst[3:0]`
  - 0001 addi
  - 0010 lw
  - 0011 sw
  - 0100 beq
  - 0101 bne
  - 0110 jump
  - 1111 halt
  - any other value is illegal
- Outputs are Moore-decoded from `state`. The only exception is `pc_write` in S_BR. Any output not listed for a state is 0.
- Reset:
  - Asserting reset forces state S_INIT (0) immediately, asynchronously. The wait counter clears and all outputs go to 0, including `state` = 0.
  - S_INIT moves unconditionally to S_FETCH on the next edge.
  - Reset mid-instruction abandons the instruction; no partial memory or register write follows.
- S_FETCH (1): `mem_read`=1, `iord`=0, `ir_write`=1, `pc_write`=1, `pc_src`=00, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ALU_ADD.
  - Stays here for MEM_WAIT extra cycles. `ir_write` and `pc_write` assert only on the final cycle; `mem_read` is held throughout.
  - Then goes to S_DECODE.
- S_DECODE (2): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=ALU_ADD (branch target into ALUOut). Next state by opcode:
  - R → S_EXR; addi → S_EXI; lw/sw → S_ADDR; beq/bne → S_BR; jump → S_JMP; halt → S_HALT
  - illegal → S_ILL
- S_EXR (3): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=`inst[3:0]`. Next: S_WB.
- S_EXI (4): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=ALU_ADD. Next: S_WB.
- S_WB (5): `reg_write`=1, `mem_to_reg`=0. Next: S_FETCH.
- S_ADDR (6): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=ALU_ADD. Next: lw → S_MRD, sw → S_MWR.
- S_MRD (7): `mem_read`=1, `iord`=1. Wait rules as S_FETCH. Next: S_MWB.
- S_MWB (8): `reg_write`=1, `mem_to_reg`=1. Next: S_FETCH.
- S_MWR (9): `mem_write`=1, `iord`=1, held for MEM_WAIT+1 cycles. Next: S_FETCH.
- S_BR (10): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=ALU_SUB, `pc_src`=01.
  - `pc_write` = `zero` for beq, ~`zero` for bne.
  - Next: S_FETCH.
- S_JMP (11): `pc_write`=1, `pc_src`=10. Next: S_FETCH.
- S_ILL (12): `illegal_op`=1. Next: S_FETCH (instruction skipped; PC already advanced).
- S_HALT (13): `halted`=1. Stays until reset.
- Wait counter:
  - 4-bit counter, loaded to 0 on entry to S_FETCH, S_MRD and S_MWR.
  - Increments each cycle in those states.
  - Exits when counter == MEM_WAIT.
- Instruction latency:
  - With MEM_WAIT=0: R/addi 4 cycles, lw 5, sw 4, beq/bne 3, jump 3, illegal 3.
  - Each memory state adds MEM_WAIT cycles.
- `inst` is sampled only in S_DECODE, S_EXR, S_ADDR and S_BR. The register is stable in those states because `ir_write`=0.
- Unreachable encodings (14, 15) go to S_FETCH on the next edge with all outputs 0.

Test Plan:
- Reset then release, `inst`=16'h0000, MEM_WAIT=0 → `state` 0→1→2→3→5→1. `ir_write`, `pc_write` and `mem_read` are high only in cycle 1. `alu_op`=0 in S_EXR. `reg_write`=1 in S_WB.
- `inst`=16'h2345 (lw) → states 1,2,6,7,8. `mem_read`=1 and `iord`=1 in S_MRD. `reg_write`=1 and `mem_to_reg`=1 in S_MWB. Total 5 cycles.
- `inst`=16'h4000 (beq) with `zero`=1 → `pc_write`=1, `pc_src`=01 in S_BR. With `zero`=0 → `pc_write`=0. For `inst`=16'h5000 (bne) the results are inverted.
- MEM_WAIT=2, `inst`=16'h3000 (sw) → S_FETCH lasts 3 cycles with `ir_write` only on the 3rd. S_MWR holds `mem_write`=1 for 3 cycles. Total 8 cycles.
- `inst`=16'h8000 → S_ILL for one cycle with `illegal_op`=1, then S_FETCH. `inst`=16'hF000 → `halted`=1, and `state` stays 13 for 20 cycles until reset.
- Reset asserted mid-S_MRD, away from the clock edge → `state`=0 and all outputs 0 before the next edge. No `reg_write` pulse occurs.
